multicycle_control: RTL and testbench

Sequencing controller for the multicycle MIPS datapath. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback steps, and drives every datapath enable and mux select per cycle. It stalls on a memory ready handshake and flags unsupported opcodes. It shares opcode decoding and ALUOp encoding with the single-cycle control unit.

---
 rtl/mips_ctrl_pkg.sv | 68 ++++++
 rtl/mc_state_decode.sv | 92 +++++++++
 rtl/multicycle_control.sv | 96 +++++++++
 tb/tb_multicycle_control.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, multicycle state codes and datapath select encodings.
// Imported by both the single-cycle and multicycle control units.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_BITS = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;

  localparam logic [SEL_W-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRC_B_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [STATE_BITS-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_I_EXEC    = 4'd8,
    ST_I_WB      = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
  } state_t;

  // One cycle's worth of datapath controls before PC-enable merging and reset gating.
  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_source;
    logic             instr_done;
    logic             illegal_op;
  } ctrl_word_t;

  function automatic logic op_supported(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_state_decode.sv
// Combinational Moore decode of the multicycle state into a control word.
// mem_ready qualifies the handshake states; illegal flags DECODE of an unsupported opcode.
module mc_state_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       illegal,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.i_or_d    = 1'b0;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      // Branch target is precomputed here while the opcode is being decoded.
      ST_DECODE: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRC_B_IMM_SH;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.illegal_op = illegal;
        ctrl.instr_done = illegal;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.i_or_d     = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_I_WB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_source  = PC_SRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: state register, next-state logic and
// reset gating of the decoded control word. All outputs are combinational.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
);

  state_t     state_q;
  state_t     state_d;
  ctrl_word_t ctrl;
  logic       illegal;

  assign illegal = !op_supported(opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Opcode is only consulted in DECODE and MEM_ADDR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_ADDI:      state_d = ST_I_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_I_EXEC:    state_d = ST_I_WB;
      ST_I_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  mc_state_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .illegal   (illegal),
    .ctrl      (ctrl)
  );

  // While reset is low every write strobe and pulse is suppressed and a fetch read is requested.
  assign pc_en      = rst_n & (ctrl.pc_write | (ctrl.pc_write_cond & zero));
  assign ir_write   = rst_n & ctrl.ir_write;
  assign mem_write  = rst_n & ctrl.mem_write;
  assign reg_write  = rst_n & ctrl.reg_write;
  assign mem_read   = ~rst_n | ctrl.mem_read;
  assign instr_done = rst_n & ctrl.instr_done;
  assign illegal_op = rst_n & ctrl.illegal_op;

  assign i_or_d     = ctrl.i_or_d;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle vector bench for multicycle_control: a table of per-cycle inputs and
// expected state/strobes feeds a scoreboard queue, plus a hand sequence for mid-flight reset.
module tb_multicycle_control;

  localparam int unsigned S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3,
                          S_MEM_WB = 4, S_MEM_WRITE = 5, S_R_EXEC = 6, S_R_WB = 7,
                          S_I_EXEC = 8, S_I_WB = 9, S_BRANCH = 10, S_JUMP = 11;

  // strobe bits: {pc_en, ir_write, mem_read, mem_write, reg_write, instr_done, illegal_op}
  localparam logic [6:0] SB_NONE  = 7'b0000000;
  localparam logic [6:0] SB_FRD   = 7'b0010000;
  localparam logic [6:0] SB_FETCH = 7'b1110000;
  localparam logic [6:0] SB_WB    = 7'b0000110;
  localparam logic [6:0] SB_PCDN  = 7'b1000010;
  localparam logic [6:0] SB_DONE  = 7'b0000010;
  localparam logic [6:0] SB_ILL   = 7'b0000011;
  localparam logic [6:0] SB_MW    = 7'b0001000;
  localparam logic [6:0] SB_MWDN  = 7'b0001010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal_op (illegal_op),
    .instr_done (instr_done),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [6:0] strb;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic [6:0] strb;
    logic [9:0] mux;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // {i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source} expected per state
  function automatic logic [9:0] exp_mux(input logic [3:0] st);
    case (st)
      4'd0:  return 10'b0000_01_00_00;
      4'd1:  return 10'b0000_11_00_00;
      4'd2:  return 10'b0001_10_00_00;
      4'd3:  return 10'b1000_00_00_00;
      4'd4:  return 10'b0010_00_00_00;
      4'd5:  return 10'b1000_00_00_00;
      4'd6:  return 10'b0001_00_10_00;
      4'd7:  return 10'b0100_00_00_00;
      4'd8:  return 10'b0001_10_00_00;
      4'd9:  return 10'b0000_00_00_00;
      4'd10: return 10'b0001_00_01_01;
      4'd11: return 10'b0000_00_00_10;
      default: return 10'b0;
    endcase
  endfunction

  function automatic void add(input logic r, input logic [5:0] op, input logic z,
                              input logic rdy, input int unsigned st,
                              input logic [6:0] strb, input string name);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.rdy = rdy;
    v.st = 4'(st); v.strb = strb; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    rst_n = v.rst; opcode = v.op; zero = v.z; mem_ready = v.rdy;
    e.st = v.st; e.strb = v.strb; e.mux = exp_mux(v.st); e.name = v.name;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check({got.name, ".state"}, 32'(state), 32'(got.st));
    check({got.name, ".strobes"},
          32'({pc_en, ir_write, mem_read, mem_write, reg_write, instr_done, illegal_op}),
          32'(got.strb));
    check({got.name, ".mux"},
          32'({i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source}),
          32'(got.mux));
  endtask

  initial begin
    // reset holds FETCH, suppresses fetch writes even with mem_ready high
    add(0, 6'd0,  0, 1, S_FETCH,     SB_FRD,   "rst0");
    add(0, 6'd0,  0, 0, S_FETCH,     SB_FRD,   "rst1");
    // lw, zero wait: 5 cycles
    add(1, 6'd35, 0, 1, S_FETCH,     SB_FETCH, "lw.fetch");
    add(1, 6'd35, 0, 1, S_DECODE,    SB_NONE,  "lw.decode");
    add(1, 6'd35, 0, 1, S_MEM_ADDR,  SB_NONE,  "lw.addr");
    add(1, 6'd35, 0, 1, S_MEM_READ,  SB_FRD,   "lw.read");
    add(1, 6'd35, 0, 1, S_MEM_WB,    SB_WB,    "lw.wb");
    // R-type then addi back to back: 8 cycles
    add(1, 6'd0,  0, 1, S_FETCH,     SB_FETCH, "r.fetch");
    add(1, 6'd0,  0, 1, S_DECODE,    SB_NONE,  "r.decode");
    add(1, 6'd0,  0, 1, S_R_EXEC,    SB_NONE,  "r.exec");
    add(1, 6'd0,  0, 1, S_R_WB,      SB_WB,    "r.wb");
    add(1, 6'd8,  0, 1, S_FETCH,     SB_FETCH, "addi.fetch");
    add(1, 6'd8,  0, 1, S_DECODE,    SB_NONE,  "addi.decode");
    add(1, 6'd8,  0, 1, S_I_EXEC,    SB_NONE,  "addi.exec");
    add(1, 6'd8,  0, 1, S_I_WB,      SB_WB,    "addi.wb");
    // beq taken then not taken
    add(1, 6'd4,  1, 1, S_FETCH,     SB_FETCH, "beq1.fetch");
    add(1, 6'd4,  1, 1, S_DECODE,    SB_NONE,  "beq1.decode");
    add(1, 6'd4,  1, 1, S_BRANCH,    SB_PCDN,  "beq1.branch");
    add(1, 6'd4,  0, 1, S_FETCH,     SB_FETCH, "beq0.fetch");
    add(1, 6'd4,  0, 1, S_DECODE,    SB_NONE,  "beq0.decode");
    add(1, 6'd4,  0, 1, S_BRANCH,    SB_DONE,  "beq0.branch");
    // j
    add(1, 6'd2,  0, 1, S_FETCH,     SB_FETCH, "j.fetch");
    add(1, 6'd2,  0, 1, S_DECODE,    SB_NONE,  "j.decode");
    add(1, 6'd2,  0, 1, S_JUMP,      SB_PCDN,  "j.jump");
    // illegal opcode 63, then FETCH stalls on mem_ready
    add(1, 6'd63, 0, 1, S_FETCH,     SB_FETCH, "ill.fetch");
    add(1, 6'd63, 0, 1, S_DECODE,    SB_ILL,   "ill.decode");
    add(1, 6'd63, 0, 0, S_FETCH,     SB_FRD,   "ill.refetch");
    add(1, 6'd63, 0, 0, S_FETCH,     SB_FRD,   "fetch.stall");
    // sw with three wait cycles in MEM_WRITE: 7 cycles
    add(1, 6'd43, 0, 1, S_FETCH,     SB_FETCH, "sw.fetch");
    add(1, 6'd43, 0, 1, S_DECODE,    SB_NONE,  "sw.decode");
    add(1, 6'd43, 0, 1, S_MEM_ADDR,  SB_NONE,  "sw.addr");
    add(1, 6'd43, 0, 0, S_MEM_WRITE, SB_MW,    "sw.wait1");
    add(1, 6'd43, 0, 0, S_MEM_WRITE, SB_MW,    "sw.wait2");
    add(1, 6'd43, 0, 0, S_MEM_WRITE, SB_MW,    "sw.wait3");
    add(1, 6'd43, 0, 1, S_MEM_WRITE, SB_MWDN,  "sw.done");
    // lw with fetch and read waits; opcode changes outside DECODE/MEM_ADDR ignored
    add(1, 6'd0,  0, 0, S_FETCH,     SB_FRD,   "lw2.fwait");
    add(1, 6'd35, 0, 1, S_FETCH,     SB_FETCH, "lw2.fetch");
    add(1, 6'd35, 0, 1, S_DECODE,    SB_NONE,  "lw2.decode");
    add(1, 6'd35, 0, 1, S_MEM_ADDR,  SB_NONE,  "lw2.addr");
    add(1, 6'd43, 0, 0, S_MEM_READ,  SB_FRD,   "lw2.rwait");
    add(1, 6'd43, 1, 1, S_MEM_READ,  SB_FRD,   "lw2.read");
    add(1, 6'd0,  1, 1, S_MEM_WB,    SB_WB,    "lw2.wb");
    add(1, 6'd43, 0, 1, S_FETCH,     SB_FETCH, "sw2.fetch");

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Mid-flight reset while MEM_WRITE completes
    @(posedge clk); #1; opcode = 6'd43; mem_ready = 1'b0;
    @(negedge clk); check("mid.decode", 32'(state), S_DECODE);
    @(posedge clk); #1;
    @(negedge clk); check("mid.addr", 32'(state), S_MEM_ADDR);
    @(posedge clk); #1; mem_ready = 1'b1;
    @(negedge clk);
    check("mid.write_state", 32'(state), S_MEM_WRITE);
    check("mid.write_pre", 32'({mem_write, instr_done}), 32'b11);
    #2; rst_n = 1'b0;
    #1;
    check("mid.rst_state", 32'(state), S_FETCH);
    check("mid.rst_strobes",
          32'({pc_en, ir_write, mem_read, mem_write, reg_write, instr_done, illegal_op}),
          32'(SB_FRD));
    @(posedge clk); #1;
    check("mid.rst_hold",
          32'({state, pc_en, ir_write, mem_write, reg_write, instr_done}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid.release",
          32'({state, pc_en, ir_write, mem_read}), 32'b0000_111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
